// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide for the execute stage: radix-2 shift-add multiply and
// restoring magnitude divide, WIDTH iterations each, result registered on entry to DONE.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrlMult,
  input  logic             ctrlDiv,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       rdIn,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             resultRDY,
  output logic [4:0]       rdOut,
  output logic             activeMultOrDiv
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;      // mult: {partial sum, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic               neg_q, neg_d, dz_q, dz_d, dovf_q, dovf_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic [4:0]         rdo_q, rdo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, shl, diff;
  logic [2*WIDTH-1:0] mult_nxt, div_nxt, prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic               last;

  assign a_mag = operandA[WIDTH-1] ? -operandA : operandA;
  assign b_mag = operandB[WIDTH-1] ? -operandB : operandB;
  assign last  = (cnt_q == CW'(WIDTH-1));

  assign add_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, bmag_q} : '0);
  assign mult_nxt = {add_sum, p_q[WIDTH-1:1]};

  assign shl     = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign diff    = shl - {1'b0, bmag_q};
  assign div_nxt = diff[WIDTH] ? {shl[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  assign prod_s = neg_q ? -mult_nxt : mult_nxt;
  assign quo_s  = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    bmag_d  = bmag_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    dovf_d  = dovf_q;
    rd_d    = rd_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdo_d   = rdo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (ctrlMult || ctrlDiv) begin
          // Multiply takes priority when both pulses arrive together.
          state_d = ctrlMult ? MULT : DIV;
          cnt_d   = '0;
          rd_d    = rdIn;
          neg_d   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
          dz_d    = (operandB == '0);
          dovf_d  = (operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (operandB == '1);
          p_d     = {{WIDTH{1'b0}}, (ctrlMult ? b_mag : a_mag)};
          bmag_d  = ctrlMult ? a_mag : b_mag;
        end
      end
      MULT: begin
        p_d   = mult_nxt;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = prod_s[WIDTH-1:0];
          exc_d   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
          rdo_d   = rd_q;
        end
      end
      DIV: begin
        p_d   = div_nxt;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = dz_q ? '0 : quo_s;
          exc_d   = dz_q | dovf_q;
          rdo_d   = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      bmag_q  <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      dovf_q  <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      bmag_q  <= bmag_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      dovf_q  <= dovf_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdo_q   <= rdo_d;
    end
  end

  assign result          = res_q;
  assign exception       = exc_q;
  assign rdOut           = rdo_q;
  assign resultRDY       = (state_q == DONE);
  assign activeMultOrDiv = (state_q == MULT) || (state_q == DIV);
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: fixed-latency mult/div results, exceptions,
// back-to-back issue, mid-op reset and simultaneous start pulses.
module tb_multdiv_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrlMult, ctrlDiv;
  logic [31:0] operandA, operandB;
  logic [4:0]  rdIn;
  logic [31:0] result;
  logic        exception, resultRDY, activeMultOrDiv;
  logic [4:0]  rdOut;

  int n_tests = 0;
  int n_fail  = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .ctrlMult(ctrlMult), .ctrlDiv(ctrlDiv),
    .operandA(operandA), .operandB(operandB), .rdIn(rdIn),
    .result(result), .exception(exception), .resultRDY(resultRDY),
    .rdOut(rdOut), .activeMultOrDiv(activeMultOrDiv)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle start pulse; returns at the negedge just after the start edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    @(negedge clock);
    ctrlMult = m; ctrlDiv = d; operandA = a; operandB = b; rdIn = rd;
    @(negedge clock);
    ctrlMult = 1'b0; ctrlDiv = 1'b0;
  endtask

  // Called at the negedge after the start edge; returns at the negedge inside DONE.
  task automatic finish_op(input string tag, input logic [31:0] er, input logic ee,
                           input logic [4:0] erd);
    int n;
    int act;
    n = 1; act = 0;
    while (!resultRDY && n < 100) begin
      if (activeMultOrDiv) act++;
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_active_cycles"}, act, 32);
    chk({tag, "_result"}, result, er);
    chk({tag, "_exception"}, exception, ee);
    chk({tag, "_rdOut"}, rdOut, erd);
    chk({tag, "_active_in_done"}, activeMultOrDiv, 1'b0);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clock);
    chk({tag, "_rdy_drop"}, resultRDY, 1'b0);
    chk({tag, "_idle"}, activeMultOrDiv, 1'b0);
  endtask

  initial begin
    int rdy_seen;
    reset = 1'b1; ctrlMult = 1'b0; ctrlDiv = 1'b0;
    operandA = '0; operandB = '0; rdIn = '0;
    #1;
    chk("reset_result", result, 0);
    chk("reset_exception", exception, 0);
    chk("reset_rdy", resultRDY, 0);
    chk("reset_rdOut", rdOut, 0);
    chk("reset_active", activeMultOrDiv, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    start_op(1, 0, 32'd7, 32'd6, 5'd5);
    finish_op("mul_7x6", 32'd42, 1'b0, 5'd5);
    idle_chk("mul_7x6");

    start_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd1);
    finish_op("mul_ovf", 32'hFFFF_FFFE, 1'b1, 5'd1);
    idle_chk("mul_ovf");

    start_op(1, 0, -32'sd3, 32'd4, 5'd2);
    finish_op("mul_neg", 32'hFFFF_FFF4, 1'b0, 5'd2);
    idle_chk("mul_neg");

    start_op(0, 1, -32'sd7, 32'd2, 5'd3);
    finish_op("div_neg", 32'hFFFF_FFFD, 1'b0, 5'd3);
    idle_chk("div_neg");

    start_op(0, 1, 32'd5, 32'd0, 5'd4);
    finish_op("div_zero", 32'd0, 1'b1, 5'd4);
    idle_chk("div_zero");

    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    finish_op("div_ovf", 32'h8000_0000, 1'b1, 5'd6);
    idle_chk("div_ovf");

    start_op(0, 1, -32'sd100, -32'sd7, 5'd7);
    finish_op("div_negneg", 32'd14, 1'b0, 5'd7);
    idle_chk("div_negneg");

    // Back-to-back: mult request pulsed during the divide's DONE cycle.
    start_op(0, 1, 32'd100, 32'd7, 5'd8);
    finish_op("b2b_div", 32'd14, 1'b0, 5'd8);
    ctrlMult = 1'b1; operandA = 32'd3; operandB = 32'd3; rdIn = 5'd9;
    @(negedge clock);
    ctrlMult = 1'b0;
    chk("b2b_active_rise", activeMultOrDiv, 1'b1);
    chk("b2b_rdy_low", resultRDY, 1'b0);
    finish_op("b2b_mul", 32'd9, 1'b0, 5'd9);
    idle_chk("b2b_mul");

    start_op(1, 1, 32'd6, 32'd3, 5'd10);
    finish_op("both_ctrl", 32'd18, 1'b0, 5'd10);
    idle_chk("both_ctrl");

    // Reset 10 cycles into a multiply; outputs still hold the previous result.
    start_op(1, 0, 32'h1234, 32'd5, 5'd11);
    repeat (9) @(negedge clock);
    chk("pre_reset_active", activeMultOrDiv, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_reset_result", result, 0);
    chk("mid_reset_rdOut", rdOut, 0);
    chk("mid_reset_active", activeMultOrDiv, 0);
    chk("mid_reset_rdy", resultRDY, 0);
    @(negedge clock);
    reset = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (resultRDY || activeMultOrDiv) rdy_seen++;
    end
    chk("post_reset_quiet", rdy_seen, 0);

    start_op(1, 0, -32'sd5, -32'sd5, 5'd12);
    finish_op("post_reset_mul", 32'd25, 1'b0, 5'd12);
    idle_chk("post_reset_mul");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
